hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width.
REQ-002 SHALL have parameter NUM_RD_PORTS, default 2: ID-stage source operands resolved in parallel (1..4).
REQ-003 SHALL have parameter LD_LAT, default 1: stall cycles per load-use hazard (1..7).
REQ-004 SHALL have clk  in  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have rst  in  1: reset, synchronous, active-high.
REQ-006 SHALL have id_valid  in  1: ID stage holds a valid instruction.
REQ-007 SHALL have id_rs_sel  in  5*NUM_RD_PORTS: packed source register indices; port p uses bits [5p+4:5p].
REQ-008 SHALL have rgf_rs_val  in  XLEN*NUM_RD_PORTS: register-file read data, packed per port.
REQ-009 SHALL have ex_wr_en, ex_is_load  in  1 each; ex_rd_sel  in  5; ex_rd_val  in  XLEN: EX-stage writeback candidate.
REQ-010 SHALL have mem_wr_en  in  1; mem_rd_sel  in  5; mem_rd_val  in  XLEN: MEM-stage writeback candidate.
REQ-011 SHALL have wb_wr_en  in  1; wb_rd_sel  in  5; wb_rd_val  in  XLEN: WB-stage writeback candidate.
REQ-012 SHALL have flush  in  1: pipeline flush (branch/trap).
REQ-013 SHALL have fwd_val  out  XLEN*NUM_RD_PORTS: resolved operand values, packed per port.
REQ-014 SHALL have fwd_src  out  2*NUM_RD_PORTS: per-port source code (0 RGF, 1 EX, 2 MEM, 3 WB).
REQ-015 SHALL have stall  out  1: hold PC/IF/ID and inject a bubble into EX.
REQ-016 SHALL have perf_stall_cycles, perf_hazards  out  32 each: performance counters.

Function
REQ-017 For each port, fwd_val SHALL be selected by priority EX > MEM > WB > RGF, a stage matching only when its wr_en=1 and its rd_sel equals id_rs_sel.
REQ-018 A source index of 0 SHALL always select RGF with value forced to 0, regardless of stage matches.
REQ-019 Forwarding SHALL be combinational (zero latency) and independent of the state machine.
REQ-020 A load-use hit SHALL exist when id_valid=1, ex_wr_en=1, ex_is_load=1, ex_rd_sel!=0, and any port's id_rs_sel equals ex_rd_sel.
REQ-021 The state machine SHALL have states IDLE and LD_WAIT plus a 3-bit down-counter cnt.
REQ-022 In IDLE, a hit SHALL assert stall combinationally in that cycle; the next state SHALL be LD_WAIT with cnt=LD_LAT-1.
REQ-023 In LD_WAIT, stall SHALL equal (cnt!=0); cnt SHALL decrement while nonzero; at cnt==0 the state SHALL return to IDLE in the next cycle.
REQ-024 Each hazard SHALL therefore produce exactly LD_LAT consecutive stall cycles.
REQ-025 Hits SHALL NOT be evaluated in LD_WAIT.
REQ-026 flush=1 SHALL force stall=0 combinationally and the next state to IDLE with cnt=0; flush SHALL win over a simultaneous hit.
REQ-027 When a hit coincides with a matching MEM/WB entry, stall SHALL still assert, and forwarding SHALL still report EX priority.

Reset
REQ-028 While rst=1, stall SHALL be 0; at the clock edge the state SHALL become IDLE, cnt 0, and both perf counters 0.
REQ-029 rst asserted in LD_WAIT SHALL abort the stall; no residual stall SHALL follow rst deassertion.

Configuration
REQ-030 Macro HAZARD_FWD_PERF_EN defined: perf_stall_cycles SHALL increment each cycle stall=1, and perf_hazards SHALL increment on each IDLE->LD_WAIT transition, both wrapping at 2^32.
REQ-031 Macro HAZARD_FWD_PERF_EN undefined: both counter ports SHALL remain present and be tied to 0, and no counter flops SHALL be inferred.

Structure
REQ-032 Package hazard_pkg SHALL hold REG_ADDR_W=5, the fwd_src encoding constants, and the state enum {IDLE, LD_WAIT}.
REQ-033 Sub-module fwd_mux (one port's priority select plus x0 guard) SHALL be instantiated NUM_RD_PORTS times via generate.

Verification
REQ-034 Bench SHALL check: rs1=5, EX wr x5=0xAAAA, MEM wr x5=0xBBBB, WB wr x5=0xCCCC -> fwd_val port0=0xAAAA, fwd_src=1; drop EX -> 0xBBBB, src=2; drop MEM -> 0xCCCC, src=3.
REQ-035 Bench SHALL check: rs2=0, EX wr x0=0x1234 -> fwd_val port1=0, src=0; same with ex_wr_en=0 and rd=7, rs2=7 -> RGF value.
REQ-036 Bench SHALL check: LD_LAT=2, load to x3 in EX, rs1=3 -> stall=1 for exactly 2 cycles, then 0; perf_hazards=1, perf_stall_cycles=2 (macro on).
REQ-037 Bench SHALL check: hit and flush in the same cycle -> stall=0, state IDLE next cycle; flush in the first LD_WAIT cycle (LD_LAT=3) -> stall=0 immediately and thereafter.
REQ-038 Bench SHALL check: rst pulsed during LD_WAIT -> stall=0 during and after, counters=0.
REQ-039 Bench SHALL check: macro off, repeat REQ-036 -> perf ports stay 0 while stall behaviour is unchanged.

Source files
------------

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types and constants for the hazard/forwarding unit: register index width,
// operand source encoding and the load-use state machine states.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] SRC_RGF = 2'd0;
  localparam logic [1:0] SRC_EX  = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;
  localparam logic [1:0] SRC_WB  = 2'd3;

  typedef enum logic {
    IDLE,
    LD_WAIT
  } state_e;

endpackage

// File: rtl/hazard_fwd_unit_fwd_mux.sv
// One ID-stage operand: priority select EX > MEM > WB > register file,
// with register x0 always reading as zero from the register file.
module fwd_mux
  import hazard_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [REG_ADDR_W-1:0] rs_sel,
  input  logic [XLEN-1:0]       rgf_val,
  input  logic                  ex_wr_en,
  input  logic [REG_ADDR_W-1:0] ex_rd_sel,
  input  logic [XLEN-1:0]       ex_rd_val,
  input  logic                  mem_wr_en,
  input  logic [REG_ADDR_W-1:0] mem_rd_sel,
  input  logic [XLEN-1:0]       mem_rd_val,
  input  logic                  wb_wr_en,
  input  logic [REG_ADDR_W-1:0] wb_rd_sel,
  input  logic [XLEN-1:0]       wb_rd_val,
  output logic [XLEN-1:0]       val,
  output logic [1:0]            src
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    val = rgf_val;
    src = SRC_RGF;
    if (rs_sel == '0) begin
      val = '0;
    end else if (ex_wr_en && (ex_rd_sel == rs_sel)) begin
      val = ex_rd_val;
      src = SRC_EX;
    end else if (mem_wr_en && (mem_rd_sel == rs_sel)) begin
      val = mem_rd_val;
      src = SRC_MEM;
    end else if (wb_wr_en && (wb_rd_sel == rs_sel)) begin
      val = wb_rd_val;
      src = SRC_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding plus load-use stall generation for a 5-stage pipeline.
// Define HAZARD_FWD_PERF_EN to build the stall/hazard performance counters.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int LD_LAT       = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               id_valid,
  input  logic [REG_ADDR_W*NUM_RD_PORTS-1:0] id_rs_sel,
  input  logic [XLEN*NUM_RD_PORTS-1:0]       rgf_rs_val,
  input  logic                               ex_wr_en,
  input  logic                               ex_is_load,
  input  logic [REG_ADDR_W-1:0]              ex_rd_sel,
  input  logic [XLEN-1:0]                    ex_rd_val,
  input  logic                               mem_wr_en,
  input  logic [REG_ADDR_W-1:0]              mem_rd_sel,
  input  logic [XLEN-1:0]                    mem_rd_val,
  input  logic                               wb_wr_en,
  input  logic [REG_ADDR_W-1:0]              wb_rd_sel,
  input  logic [XLEN-1:0]                    wb_rd_val,
  input  logic                               flush,
  output logic [XLEN*NUM_RD_PORTS-1:0]       fwd_val,
  output logic [2*NUM_RD_PORTS-1:0]          fwd_src,
  output logic                               stall,
  output logic [31:0]                        perf_stall_cycles,
  output logic [31:0]                        perf_hazards
);

  localparam logic [2:0] LD_INIT = 3'(LD_LAT - 1);

  state_e     state;
  logic [2:0] cnt;
  logic       rs_match;
  logic       ld_hit;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    fwd_mux #(.XLEN(XLEN)) u_fwd_mux (
      .rs_sel     (id_rs_sel[p*REG_ADDR_W +: REG_ADDR_W]),
      .rgf_val    (rgf_rs_val[p*XLEN +: XLEN]),
      .ex_wr_en   (ex_wr_en),
      .ex_rd_sel  (ex_rd_sel),
      .ex_rd_val  (ex_rd_val),
      .mem_wr_en  (mem_wr_en),
      .mem_rd_sel (mem_rd_sel),
      .mem_rd_val (mem_rd_val),
      .wb_wr_en   (wb_wr_en),
      .wb_rd_sel  (wb_rd_sel),
      .wb_rd_val  (wb_rd_val),
      .val        (fwd_val[p*XLEN +: XLEN]),
      .src        (fwd_src[p*2 +: 2])
    );
  end

  always_comb begin
    rs_match = 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (id_rs_sel[p*REG_ADDR_W +: REG_ADDR_W] == ex_rd_sel) rs_match = 1'b1;
    end
  end

  assign ld_hit = id_valid && ex_wr_en && ex_is_load && (ex_rd_sel != '0) && rs_match;

  // Stall is combinational so the hazard cycle itself is held; reset and flush mask it.
  always_comb begin
    stall = 1'b0;
    if (!rst && !flush) begin
      case (state)
        IDLE:    stall = ld_hit;
        LD_WAIT: stall = (cnt != 3'd0);
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments; reset is synchronous and active-high here.
    if (rst || flush) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_hit) begin
            state <= LD_WAIT;
            cnt   <= LD_INIT;
          end
        end
        LD_WAIT: begin
          if (cnt != 3'd0) cnt <= cnt - 3'd1;
          else             state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_FWD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] hazard_cnt_q;
  logic        hazard_start;

  assign hazard_start = !rst && !flush && (state == IDLE) && ld_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= 32'd0;
      hazard_cnt_q <= 32'd0;
    end else begin
      if (stall)        stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (hazard_start) hazard_cnt_q <= hazard_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_hazards      = hazard_cnt_q;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_hazards      = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: two instances (LD_LAT=2 and LD_LAT=3)
// share stimulus; expectations are queued at drive time and compared on the falling edge.
module tb_hazard_fwd_unit;

  localparam int XLEN = 32;
  localparam int NP   = 2;
`ifdef HAZARD_FWD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [5*NP-1:0]   id_rs_sel;
  logic [XLEN*NP-1:0] rgf_rs_val;
  logic              ex_wr_en, ex_is_load;
  logic [4:0]        ex_rd_sel;
  logic [XLEN-1:0]   ex_rd_val;
  logic              mem_wr_en;
  logic [4:0]        mem_rd_sel;
  logic [XLEN-1:0]   mem_rd_val;
  logic              wb_wr_en;
  logic [4:0]        wb_rd_sel;
  logic [XLEN-1:0]   wb_rd_val;
  logic              flush;

  logic [XLEN*NP-1:0] fwd_val2, fwd_val3;
  logic [2*NP-1:0]    fwd_src2, fwd_src3;
  logic               stall2, stall3;
  logic [31:0]        perf_stall2, perf_haz2, perf_stall3, perf_haz3;

  hazard_fwd_unit #(.XLEN(XLEN), .NUM_RD_PORTS(NP), .LD_LAT(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_sel(id_rs_sel), .rgf_rs_val(rgf_rs_val),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd_sel(ex_rd_sel), .ex_rd_val(ex_rd_val),
    .mem_wr_en(mem_wr_en), .mem_rd_sel(mem_rd_sel), .mem_rd_val(mem_rd_val),
    .wb_wr_en(wb_wr_en), .wb_rd_sel(wb_rd_sel), .wb_rd_val(wb_rd_val), .flush(flush),
    .fwd_val(fwd_val2), .fwd_src(fwd_src2), .stall(stall2),
    .perf_stall_cycles(perf_stall2), .perf_hazards(perf_haz2)
  );

  hazard_fwd_unit #(.XLEN(XLEN), .NUM_RD_PORTS(NP), .LD_LAT(3)) dut_lat3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_sel(id_rs_sel), .rgf_rs_val(rgf_rs_val),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd_sel(ex_rd_sel), .ex_rd_val(ex_rd_val),
    .mem_wr_en(mem_wr_en), .mem_rd_sel(mem_rd_sel), .mem_rd_val(mem_rd_val),
    .wb_wr_en(wb_wr_en), .wb_rd_sel(wb_rd_sel), .wb_rd_val(wb_rd_val), .flush(flush),
    .fwd_val(fwd_val3), .fwd_src(fwd_src3), .stall(stall3),
    .perf_stall_cycles(perf_stall3), .perf_hazards(perf_haz3)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic void expect_val(string n, logic [31:0] v);
    sb_t e;
    e.name = n;
    e.exp  = v;
    sb_q.push_back(e);
  endfunction

  // Reference forwarding model for one port: {src, value}.
  function automatic logic [33:0] model_port(logic [4:0] rs, logic [31:0] rgf);
    if (rs == 5'd0)                        return {2'd0, 32'd0};
    if (ex_wr_en  && (ex_rd_sel  == rs))   return {2'd1, ex_rd_val};
    if (mem_wr_en && (mem_rd_sel == rs))   return {2'd2, mem_rd_val};
    if (wb_wr_en  && (wb_rd_sel  == rs))   return {2'd3, wb_rd_val};
    return {2'd0, rgf};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs_sel = '0; rgf_rs_val = '0; flush = 0;
    ex_wr_en = 0; ex_is_load = 0; ex_rd_sel = '0; ex_rd_val = '0;
    mem_wr_en = 0; mem_rd_sel = '0; mem_rd_val = '0;
    wb_wr_en = 0; wb_rd_sel = '0; wb_rd_val = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic drive_load_hit(logic [4:0] rd);
    id_valid   = 1;
    id_rs_sel  = {5'd9, rd};
    ex_wr_en   = 1;
    ex_is_load = 1;
    ex_rd_sel  = rd;
    ex_rd_val  = 32'hDEAD_0000;
  endtask

  task automatic test_reset();
    logic [31:0] o[$];
    sb_t e;
    clear_inputs();
    drive_load_hit(5'd3);
    rst = 1;
    expect_val("reset_stall_lat2", 32'd0);
    expect_val("reset_stall_lat3", 32'd0);
    @(negedge clk);
    o.delete(); o.push_back(32'(stall2)); o.push_back(32'(stall3));
    step();
    expect_val("reset_perf_stall", 32'd0);
    expect_val("reset_perf_haz", 32'd0);
    expect_val("reset_stall_held", 32'd0);
    @(negedge clk);
    o.push_back(perf_stall2); o.push_back(perf_haz2); o.push_back(32'(stall2));
    foreach (o[k]) begin
      e = sb_q.pop_front(); n_checks++;
      if (o[k] !== e.exp) begin
        n_errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o[k], e.exp);
      end
    end
    rst = 0;
    clear_inputs();
    step();
  endtask

  task automatic test_fwd_priority();
    logic [31:0] o[$];
    sb_t e;
    apply_reset();
    id_rs_sel  = {5'd6, 5'd5};
    rgf_rs_val = {32'h0000_2222, 32'h0000_1111};
    ex_wr_en  = 1; ex_rd_sel  = 5'd5; ex_rd_val  = 32'hAAAA;
    mem_wr_en = 1; mem_rd_sel = 5'd5; mem_rd_val = 32'hBBBB;
    wb_wr_en  = 1; wb_rd_sel  = 5'd5; wb_rd_val  = 32'hCCCC;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin expect_val("prio_ex_val", 32'hAAAA); expect_val("prio_ex_src", 32'd1); end
        1: begin expect_val("prio_mem_val", 32'hBBBB); expect_val("prio_mem_src", 32'd2); end
        2: begin expect_val("prio_wb_val", 32'hCCCC); expect_val("prio_wb_src", 32'd3); end
        default: begin expect_val("prio_rgf_val", 32'h1111); expect_val("prio_rgf_src", 32'd0); end
      endcase
      expect_val("prio_port1_val", 32'h2222);
      expect_val("prio_port1_src", 32'd0);
      @(negedge clk);
      o.delete();
      o.push_back(fwd_val2[31:0]);  o.push_back(32'(fwd_src2[1:0]));
      o.push_back(fwd_val2[63:32]); o.push_back(32'(fwd_src2[3:2]));
      foreach (o[k]) begin
        e = sb_q.pop_front(); n_checks++;
        if (o[k] !== e.exp) begin
          n_errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o[k], e.exp);
        end
      end
      step();
      if (c == 0) ex_wr_en = 0;
      if (c == 1) mem_wr_en = 0;
      if (c == 2) wb_wr_en = 0;
    end
  endtask

  task automatic test_x0_guard();
    logic [31:0] o[$];
    sb_t e;
    apply_reset();
    rgf_rs_val = {32'h0000_5555, 32'h0000_1111};
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin
          id_rs_sel = {5'd0, 5'd1}; ex_wr_en = 1; ex_rd_sel = 5'd0; ex_rd_val = 32'h1234;
          expect_val("x0_val", 32'd0); expect_val("x0_src", 32'd0);
        end
        1: begin
          id_rs_sel = {5'd7, 5'd1}; ex_wr_en = 0; ex_rd_sel = 5'd7;
          expect_val("no_wr_rgf_val", 32'h5555); expect_val("no_wr_rgf_src", 32'd0);
        end
        default: begin
          ex_wr_en = 1;
          expect_val("x7_ex_val", 32'h1234); expect_val("x7_ex_src", 32'd1);
        end
      endcase
      @(negedge clk);
      o.delete(); o.push_back(fwd_val2[63:32]); o.push_back(32'(fwd_src2[3:2]));
      foreach (o[k]) begin
        e = sb_q.pop_front(); n_checks++;
        if (o[k] !== e.exp) begin
          n_errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o[k], e.exp);
        end
      end
      step();
    end
  endtask

  // Load to x3 in EX, consumer reads x3; the load moves on to MEM after the first cycle.
  task automatic test_load_use();
    logic [31:0] o[$];
    sb_t e;
    logic s2 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic s3 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    drive_load_hit(5'd3);
    for (int c = 0; c < 4; c++) begin
      expect_val($sformatf("ld_stall_lat2_c%0d", c), 32'(s2[c]));
      expect_val($sformatf("ld_stall_lat3_c%0d", c), 32'(s3[c]));
      @(negedge clk);
      o.delete(); o.push_back(32'(stall2)); o.push_back(32'(stall3));
      foreach (o[k]) begin
        e = sb_q.pop_front(); n_checks++;
        if (o[k] !== e.exp) begin
          n_errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o[k], e.exp);
        end
      end
      step();
      if (c == 0) begin
        ex_wr_en = 0; ex_is_load = 0;
        mem_wr_en = 1; mem_rd_sel = 5'd3; mem_rd_val = 32'hDEAD_0000;
      end
    end
    expect_val("ld_perf_haz_lat2", PERF ? 32'd1 : 32'd0);
    expect_val("ld_perf_stall_lat2", PERF ? 32'd2 : 32'd0);
    expect_val("ld_perf_haz_lat3", PERF ? 32'd1 : 32'd0);
    expect_val("ld_perf_stall_lat3", PERF ? 32'd3 : 32'd0);
    @(negedge clk);
    o.delete();
    o.push_back(perf_haz2); o.push_back(perf_stall2); o.push_back(perf_haz3); o.push_back(perf_stall3);
    foreach (o[k]) begin
      e = sb_q.pop_front(); n_checks++;
      if (o[k] !== e.exp) begin
        n_errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o[k], e.exp);
      end
    end
  endtask

  // Load hit while MEM and WB also hold x3: stall asserts and EX still wins forwarding.
  task automatic test_hit_priority();
    logic [31:0] o[$];
    sb_t e;
    apply_reset();
    drive_load_hit(5'd3);
    mem_wr_en = 1; mem_rd_sel = 5'd3; mem_rd_val = 32'hBBBB;
    wb_wr_en  = 1; wb_rd_sel  = 5'd3; wb_rd_val  = 32'hCCCC;
    expect_val("hitprio_stall", 32'd1);
    expect_val("hitprio_src", 32'd1);
    expect_val("hitprio_val", 32'hDEAD_0000);
    @(negedge clk);
    o.delete(); o.push_back(32'(stall2)); o.push_back(32'(fwd_src2[1:0])); o.push_back(fwd_val2[31:0]);
    foreach (o[k]) begin
      e = sb_q.pop_front(); n_checks++;
      if (o[k] !== e.exp) begin
        n_errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o[k], e.exp);
      end
    end
    step();
  endtask

  task automatic test_flush_same_cycle();
    logic [31:0] o[$];
    sb_t e;
    apply_reset();
    drive_load_hit(5'd3);
    flush = 1;
    for (int c = 0; c < 2; c++) begin
      expect_val($sformatf("flush_hit_stall_lat2_c%0d", c), 32'd0);
      expect_val($sformatf("flush_hit_stall_lat3_c%0d", c), 32'd0);
      expect_val($sformatf("flush_hit_perf_haz_c%0d", c), 32'd0);
      @(negedge clk);
      o.delete(); o.push_back(32'(stall2)); o.push_back(32'(stall3)); o.push_back(perf_haz2);
      foreach (o[k]) begin
        e = sb_q.pop_front(); n_checks++;
        if (o[k] !== e.exp) begin
          n_errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o[k], e.exp);
        end
      end
      step();
      clear_inputs();
    end
  endtask

  task automatic test_flush_in_wait();
    logic [31:0] o[$];
    sb_t e;
    apply_reset();
    drive_load_hit(5'd3);
    for (int c = 0; c < 4; c++) begin
      expect_val($sformatf("flush_wait_lat2_c%0d", c), (c == 0) ? 32'd1 : 32'd0);
      expect_val($sformatf("flush_wait_lat3_c%0d", c), (c == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
      o.delete(); o.push_back(32'(stall2)); o.push_back(32'(stall3));
      foreach (o[k]) begin
        e = sb_q.pop_front(); n_checks++;
        if (o[k] !== e.exp) begin
          n_errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o[k], e.exp);
        end
      end
      step();
      clear_inputs();
      flush = (c == 0);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] o[$];
    sb_t e;
    apply_reset();
    drive_load_hit(5'd3);
    for (int c = 0; c < 4; c++) begin
      expect_val($sformatf("rst_wait_lat2_c%0d", c), (c == 0) ? 32'd1 : 32'd0);
      expect_val($sformatf("rst_wait_lat3_c%0d", c), (c == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
      o.delete(); o.push_back(32'(stall2)); o.push_back(32'(stall3));
      if (c >= 2) begin
        expect_val($sformatf("rst_wait_perf_stall_c%0d", c), 32'd0);
        expect_val($sformatf("rst_wait_perf_haz_c%0d", c), 32'd0);
        o.push_back(perf_stall3); o.push_back(perf_haz3);
      end
      foreach (o[k]) begin
        e = sb_q.pop_front(); n_checks++;
        if (o[k] !== e.exp) begin
          n_errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o[k], e.exp);
        end
      end
      step();
      clear_inputs();
      rst = (c == 0);
    end
  endtask

  task automatic test_random_fwd();
    logic [31:0] o[$];
    sb_t e;
    logic [33:0] m;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      id_rs_sel  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rgf_rs_val = {$urandom, $urandom};
      ex_wr_en  = 1'($urandom); ex_rd_sel  = 5'($urandom_range(0, 3)); ex_rd_val  = $urandom;
      mem_wr_en = 1'($urandom); mem_rd_sel = 5'($urandom_range(0, 3)); mem_rd_val = $urandom;
      wb_wr_en  = 1'($urandom); wb_rd_sel  = 5'($urandom_range(0, 3)); wb_rd_val  = $urandom;
      for (int p = 0; p < NP; p++) begin
        m = model_port(id_rs_sel[p*5 +: 5], rgf_rs_val[p*32 +: 32]);
        expect_val($sformatf("rand%0d_p%0d_val", i, p), m[31:0]);
        expect_val($sformatf("rand%0d_p%0d_src", i, p), 32'(m[33:32]));
      end
      @(negedge clk);
      o.delete();
      o.push_back(fwd_val2[31:0]);  o.push_back(32'(fwd_src2[1:0]));
      o.push_back(fwd_val2[63:32]); o.push_back(32'(fwd_src2[3:2]));
      foreach (o[k]) begin
        e = sb_q.pop_front(); n_checks++;
        if (o[k] !== e.exp) begin
          n_errors++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o[k], e.exp);
        end
      end
      step();
    end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_fwd_priority();
    test_x0_guard();
    test_load_use();
    test_hit_priority();
    test_flush_same_cycle();
    test_flush_in_wait();
    test_reset_in_wait();
    test_random_fwd();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
